// File: rtl/pwm_pkg.sv
// Shared PWM definitions: decoder state encoding and the nominal timing
// constants shared with the PWM generator.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } pwm_state_e;

    localparam int NOM_PERIOD_DEFAULT = 10;
    // One duty step corresponds to one high cycle of the nominal period.
    localparam int DUTY_STEP          = 1;

endpackage

// File: rtl/pwm_edge_sync.sv
// Input synchronizer for the asynchronous PWM line, plus rising and
// falling edge detection on the synchronized level.
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;

    // Synchronizer chain and one-cycle history of the synchronized level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
            s_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = s_o & ~s_prev_q;
    assign fall_o = ~s_o & s_prev_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures high time and period of a PWM input once per period, and flags
// off-nominal periods and lines stuck high or low.
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CW          = 8,
    parameter int NOM_PERIOD  = NOM_PERIOD_DEFAULT,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_in,
    output logic [CW-1:0] high_cnt,
    output logic [CW-1:0] period_cnt,
    output logic          meas_valid,
    output logic          period_err,
    output logic          stuck_high,
    output logic          stuck_low,
    output logic          locked
);

    localparam logic [CW-1:0] NOM_C     = CW'(NOM_PERIOD);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] SAT_C     = {CW{1'b1}};
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [CW-1:0] STEP_C    = CW'(DUTY_STEP);

    logic s_s, rise_s, fall_s;

    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (pwm_in),
        .s_o     (s_s),
        .rise_o  (rise_s),
        .fall_o  (fall_s)
    );

    pwm_state_e    state_q, state_d;
    logic [CW-1:0] since_q, since_d;
    logic [CW-1:0] hi_acc_q, hi_acc_d;
    logic [CW-1:0] high_q, high_d;
    logic [CW-1:0] period_q, period_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          sh_q, sh_d;
    logic          sl_q, sl_d;
    logic          locked_q, locked_d;
    logic          timeout_s;
    logic          enter_stuck_s;

    assign timeout_s = (since_q == TIMEOUT_C);

    // Next-state, window accumulators and measurement outputs.
    always_comb begin
        state_d       = state_q;
        high_d        = high_q;
        period_d      = period_q;
        valid_d       = 1'b0;
        err_d         = err_q;
        sh_d          = sh_q;
        sl_d          = sl_q;
        locked_d      = locked_q;
        enter_stuck_s = 1'b0;

        // The rise cycle is the first cycle of the new window.
        if (rise_s) begin
            since_d  = ONE_C;
            hi_acc_d = ONE_C;
        end else begin
            since_d  = (since_q == SAT_C) ? since_q : since_q + ONE_C;
            hi_acc_d = (s_s && (hi_acc_q != SAT_C)) ? hi_acc_q + STEP_C : hi_acc_q;
        end

        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    state_d = MEASURE;
                end else if (timeout_s) begin
                    enter_stuck_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            MEASURE: begin
                if (rise_s) begin
                    period_d = since_q;
                    high_d   = hi_acc_q;
                    err_d    = (since_q != NOM_C);
                    locked_d = (since_q == NOM_C);
                    valid_d  = 1'b1;
                end else if (timeout_s) begin
                    enter_stuck_s = 1'b1;
                end else begin
                    state_d = MEASURE;
                end
            end
            STUCK: begin
                if (rise_s) begin
                    state_d = MEASURE;
                    sh_d    = 1'b0;
                    sl_d    = 1'b0;
                end else if (fall_s && sh_q) begin
                    sh_d = 1'b0;
                    sl_d = 1'b1;
                end else begin
                    state_d = STUCK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_stuck_s) begin
            state_d  = STUCK;
            sh_d     = s_s;
            sl_d     = ~s_s;
            high_d   = s_s ? NOM_C : {CW{1'b0}};
            period_d = NOM_C;
            err_d    = 1'b0;
            locked_d = 1'b0;
            valid_d  = 1'b1;
        end else begin
            state_d = state_d;
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            since_q  <= {CW{1'b0}};
            hi_acc_q <= {CW{1'b0}};
            high_q   <= {CW{1'b0}};
            period_q <= {CW{1'b0}};
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            sh_q     <= 1'b0;
            sl_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            since_q  <= since_d;
            hi_acc_q <= hi_acc_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            sh_q     <= sh_d;
            sl_q     <= sl_d;
            locked_q <= locked_d;
        end
    end

    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign meas_valid = valid_q;
    assign period_err = err_q;
    assign stuck_high = sh_q;
    assign stuck_low  = sl_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: directed and random PWM waveforms checked
// every cycle against a window/sum reference model plus directed spot checks.
module tb_pwm_duty_decoder;

    localparam int CW   = 8;
    localparam int NOM  = 10;
    localparam int TO   = 64;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] high_cnt, period_cnt;
    logic          meas_valid, period_err, stuck_high, stuck_low, locked;

    always #5 clk = ~clk;

    pwm_duty_decoder #(.CW(CW), .NOM_PERIOD(NOM), .TIMEOUT(TO), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .period_err (period_err),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low),
        .locked     (locked)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: history of the synchronized level, window start cycle, mode.
    int cyc = 0;
    bit hist [0:32767];
    bit dl [SYNC];
    bit sp;
    int mode;        // 0 idle, 1 measuring, 2 stuck
    int win_start;
    int m_high, m_period;
    bit m_valid, m_err, m_sh, m_sl, m_locked;
    int vcount;
    int lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic stuck_entry(input bit s);
        mode     = 2;
        m_sh     = s;
        m_sl     = !s;
        m_high   = s ? NOM : 0;
        m_period = NOM;
        m_err    = 1'b0;
        m_locked = 1'b0;
        m_valid  = 1'b1;
    endtask

    task automatic model_edge(input bit v, input bit r);
        bit s_cur, rise, fall;
        int c, sum;
        s_cur   = dl[SYNC-1];
        rise    = s_cur && !sp;
        fall    = !s_cur && sp;
        c       = cyc - 1;
        m_valid = 1'b0;
        if (r) begin
            for (int i = 0; i < SYNC; i++) dl[i] = 1'b0;
            sp = 1'b0; mode = 0; win_start = cyc;
            m_high = 0; m_period = 0; m_err = 0; m_sh = 0; m_sl = 0; m_locked = 0;
        end else begin
            if (mode == 0) begin
                if (rise) mode = 1;
                else if (c - win_start == TO) stuck_entry(s_cur);
            end else if (mode == 1) begin
                if (rise) begin
                    sum = 0;
                    for (int k = win_start; k < c; k++) sum += int'(hist[k]);
                    m_period = c - win_start;
                    m_high   = sum;
                    m_err    = (m_period != NOM);
                    m_locked = !m_err;
                    m_valid  = 1'b1;
                end else if (c - win_start == TO) begin
                    stuck_entry(s_cur);
                end
            end else begin
                if (rise) begin
                    mode = 1; m_sh = 0; m_sl = 0;
                end else if (fall && m_sh) begin
                    m_sh = 0; m_sl = 1;
                end
            end
            if (rise) win_start = c;
            sp = s_cur;
            for (int i = SYNC - 1; i > 0; i--) dl[i] = dl[i-1];
            dl[0] = v;
        end
        hist[cyc] = dl[SYNC-1];
    endtask

    task automatic tick(input bit v, input bit r);
        @(negedge clk);
        pwm_in = v;
        rst    = r;
        @(posedge clk);
        cyc++;
        model_edge(v, r);
        #1;
        chk("high_cnt",   high_cnt,   m_high);
        chk("period_cnt", period_cnt, m_period);
        chk("meas_valid", meas_valid, m_valid);
        chk("period_err", period_err, m_err);
        chk("stuck_high", stuck_high, m_sh);
        chk("stuck_low",  stuck_low,  m_sl);
        chk("locked",     locked,     m_locked);
        if (meas_valid === 1'b1) vcount++;
    endtask

    task automatic run_pwm(input int hi, input int per, input int n);
        for (int p = 0; p < n; p++)
            for (int k = 0; k < per; k++) tick(k < hi, 1'b0);
    endtask

    task automatic hold(input bit v, input int n);
        for (int k = 0; k < n; k++) tick(v, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);
        chk("rst_high", high_cnt, 0);
        chk("rst_locked", locked, 0);
        chk("rst_valid", meas_valid, 0);

        run_pwm(5, 10, 4);
        chk("d50_high", high_cnt, 5);
        chk("d50_period", period_cnt, 10);
        chk("d50_locked", locked, 1);

        run_pwm(6, 10, 3);
        chk("d60_high", high_cnt, 6);
        run_pwm(7, 10, 3);
        chk("d70_high", high_cnt, 7);
        run_pwm(6, 10, 3);
        chk("d60b_high", high_cnt, 6);
        chk("d60b_period", period_cnt, 10);

        vcount = 0;
        hold(1'b0, 100);
        chk("sl_valids", vcount, 1);
        chk("sl_flag", stuck_low, 1);
        chk("sl_high", high_cnt, 0);
        chk("sl_period", period_cnt, 10);
        chk("sl_locked", locked, 0);

        run_pwm(5, 10, 3);
        vcount = 0;
        hold(1'b1, 100);
        chk("sh_valids", vcount, 2);
        chk("sh_flag", stuck_high, 1);
        chk("sh_high", high_cnt, 10);
        vcount = 0;
        hold(1'b0, 5);
        chk("sh_fall_high", stuck_high, 0);
        chk("sh_fall_low", stuck_low, 1);
        chk("sh_fall_valids", vcount, 0);

        run_pwm(6, 12, 3);
        chk("p12_high", high_cnt, 6);
        chk("p12_period", period_cnt, 12);
        chk("p12_err", period_err, 1);
        chk("p12_locked", locked, 0);
        run_pwm(5, 10, 3);
        chk("p10_err", period_err, 0);
        chk("p10_locked", locked, 1);

        run_pwm(1, 10, 3);
        chk("pulse_high", high_cnt, 1);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(k == 1, 1'b0);
            if (meas_valid === 1'b1 && lat == 0) lat = k;
        end
        chk("latency", lat, SYNC + 1);
        hold(1'b0, 2);

        run_pwm(5, 10, 2);
        hold(1'b1, 3);
        tick(1'b1, 1'b1);
        chk("mid_rst_period", period_cnt, 0);
        chk("mid_rst_high", high_cnt, 0);
        vcount = 0;
        hold(1'b1, 2);
        hold(1'b0, 5);
        chk("mid_rst_one_rise", vcount, 0);
        run_pwm(5, 10, 2);
        chk("mid_rst_two_rises", vcount, 2);

        run_pwm(3, 64, 3);
        chk("p64_period", period_cnt, 64);
        chk("p64_err", period_err, 1);
        chk("p64_stuck", stuck_low, 0);

        for (int it = 0; it < 25; it++) begin
            int per, hi;
            per = int'($urandom_range(20, 2));
            hi  = int'($urandom_range(per - 1, 1));
            run_pwm(hi, per, int'($urandom_range(3, 1)));
            if ($urandom_range(3, 0) == 0) hold(1'($urandom_range(1, 0)), int'($urandom_range(80, 50)));
        end
        for (int k = 0; k < 300; k++) tick(1'($urandom_range(1, 0)), 1'b0);
        run_pwm(4, 10, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
